// File: rtl/bfu_pipe_if.sv
// rtl/bfu_pipe_if.sv - stream/handshake bundle for the bfu_pipe butterfly
interface bfu_pipe_if #(
  parameter int DATA_WIDTH = 16,
  parameter int TW_WIDTH   = 16
);
  // input beat handshake and per-beat control
  logic                         in_valid;
  logic                         in_ready;
  logic                         mode_dif;
  logic                         scale;

  // butterfly operands and twiddle
  logic signed [DATA_WIDTH-1:0] A_in_r;
  logic signed [DATA_WIDTH-1:0] A_in_i;
  logic signed [DATA_WIDTH-1:0] B_in_r;
  logic signed [DATA_WIDTH-1:0] B_in_i;
  logic signed [TW_WIDTH-1:0]   twiddleF_r;
  logic signed [TW_WIDTH-1:0]   twiddleF_i;

  // output beat handshake and results
  logic                         out_valid;
  logic                         out_ready;
  logic signed [DATA_WIDTH-1:0] A_out_r;
  logic signed [DATA_WIDTH-1:0] A_out_i;
  logic signed [DATA_WIDTH-1:0] B_out_r;
  logic signed [DATA_WIDTH-1:0] B_out_i;

  modport master (
    output in_valid, mode_dif, scale,
    output A_in_r, A_in_i, B_in_r, B_in_i, twiddleF_r, twiddleF_i,
    output out_ready,
    input  in_ready, out_valid,
    input  A_out_r, A_out_i, B_out_r, B_out_i
  );

  modport slave (
    input  in_valid, mode_dif, scale,
    input  A_in_r, A_in_i, B_in_r, B_in_i, twiddleF_r, twiddleF_i,
    input  out_ready,
    output in_ready, out_valid,
    output A_out_r, A_out_i, B_out_r, B_out_i
  );
endinterface

// File: rtl/bfu_pipe.sv
// rtl/bfu_pipe.sv - 3-stage radix-2 DIT/DIF butterfly; BFU_PIPE_OVF_FLAG_EN adds sticky ovf_flag/ovf_clr
module bfu_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int TW_WIDTH   = 16
) (
  input  logic      clk,
  input  logic      rst,
  bfu_pipe_if.slave bus
`ifdef BFU_PIPE_OVF_FLAG_EN
  ,
  input  logic      ovf_clr,
  output logic      ovf_flag
`endif
);

  // S = A+B / D = A-B need one growth bit; the rounded product keeps three
  localparam int SW = DATA_WIDTH + 1;
  localparam int PW = DATA_WIDTH + 3;
  localparam int MW = DATA_WIDTH + TW_WIDTH + 2;
  localparam int XW = DATA_WIDTH + 5;

  localparam logic signed [MW-1:0] RND  = MW'(1) <<< (TW_WIDTH - 2);
  localparam logic signed [XW-1:0] MAXV = (XW'(1) <<< (DATA_WIDTH - 1)) - XW'(1);
  localparam logic signed [XW-1:0] MINV = -(XW'(1) <<< (DATA_WIDTH - 1));

  // one global advance: every stage moves together or holds together
  logic en;
  logic v1, v2, v3;

  assign en            = !v3 || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = v3;

  // ---------------------------------------------------------------- S1
  logic signed [SW-1:0]       a_r_x, a_i_x, b_r_x, b_i_x;
  logic signed [SW-1:0]       s_r_n, s_i_n, d_r_n, d_i_n;
  logic                       m1, sc1;
  logic signed [SW-1:0]       s1_r, s1_i, d1_r, d1_i;
  logic signed [TW_WIDTH-1:0] w1_r, w1_i;

  assign a_r_x = {bus.A_in_r[DATA_WIDTH-1], bus.A_in_r};
  assign a_i_x = {bus.A_in_i[DATA_WIDTH-1], bus.A_in_i};
  assign b_r_x = {bus.B_in_r[DATA_WIDTH-1], bus.B_in_r};
  assign b_i_x = {bus.B_in_i[DATA_WIDTH-1], bus.B_in_i};

  // DIF does its add/subtract up front; DIT only forwards the operands
  always_comb begin
    s_r_n = a_r_x;
    s_i_n = a_i_x;
    d_r_n = b_r_x;
    d_i_n = b_i_x;
    if (bus.mode_dif) begin
      s_r_n = a_r_x + b_r_x;
      s_i_n = a_i_x + b_i_x;
      d_r_n = a_r_x - b_r_x;
      d_i_n = a_i_x - b_i_x;
    end
  end

  // S1 register: data only loads for a real beat so bubbles leave it untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1   <= 1'b0;
      m1   <= 1'b0;
      sc1  <= 1'b0;
      s1_r <= '0;
      s1_i <= '0;
      d1_r <= '0;
      d1_i <= '0;
      w1_r <= '0;
      w1_i <= '0;
    end else if (en) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        m1   <= bus.mode_dif;
        sc1  <= bus.scale;
        s1_r <= s_r_n;
        s1_i <= s_i_n;
        d1_r <= d_r_n;
        d1_i <= d_i_n;
        w1_r <= bus.twiddleF_r;
        w1_i <= bus.twiddleF_i;
      end
    end
  end

  // ---------------------------------------------------------------- S2
  logic signed [MW-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [MW-1:0] pr_full, pi_full;
  logic signed [PW-1:0] p_r_n, p_i_n;
  logic                 m2, sc2;
  logic signed [SW-1:0] s2_r, s2_i;
  logic signed [PW-1:0] p2_r, p2_i;

  assign m_rr    = MW'(d1_r) * MW'(w1_r);
  assign m_ii    = MW'(d1_i) * MW'(w1_i);
  assign m_ri    = MW'(d1_r) * MW'(w1_i);
  assign m_ir    = MW'(d1_i) * MW'(w1_r);
  assign pr_full = m_rr - m_ii;
  assign pi_full = m_ri + m_ir;

  // round half-up back to the Q0 data scale of the twiddle product
  assign p_r_n = PW'((pr_full + RND) >>> (TW_WIDTH - 1));
  assign p_i_n = PW'((pi_full + RND) >>> (TW_WIDTH - 1));

  // S2 register: rounded product plus the pass-through sum term
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      m2   <= 1'b0;
      sc2  <= 1'b0;
      s2_r <= '0;
      s2_i <= '0;
      p2_r <= '0;
      p2_i <= '0;
    end else if (en) begin
      v2 <= v1;
      if (v1) begin
        m2   <= m1;
        sc2  <= sc1;
        s2_r <= s1_r;
        s2_i <= s1_i;
        p2_r <= p_r_n;
        p2_i <= p_i_n;
      end
    end
  end

  // ---------------------------------------------------------------- S3
  logic signed [XW-1:0]         sx_r, sx_i, px_r, px_i;
  logic signed [XW-1:0]         x_r, x_i, y_r, y_i;
  logic signed [XW-1:0]         xs_r, xs_i, ys_r, ys_i;
  logic                         v3_unused_guard;
  logic signed [DATA_WIDTH-1:0] o_a_r, o_a_i, o_b_r, o_b_i;

  assign sx_r = XW'(s2_r);
  assign sx_i = XW'(s2_i);
  assign px_r = XW'(p2_r);
  assign px_i = XW'(p2_i);

  // DIT combines here; DIF already combined in S1 and just routes S and P
  always_comb begin
    x_r = sx_r + px_r;
    x_i = sx_i + px_i;
    y_r = sx_r - px_r;
    y_i = sx_i - px_i;
    if (m2) begin
      x_r = sx_r;
      x_i = sx_i;
      y_r = px_r;
      y_i = px_i;
    end
  end

  assign xs_r = sc2 ? ((x_r + XW'(1)) >>> 1) : x_r;
  assign xs_i = sc2 ? ((x_i + XW'(1)) >>> 1) : x_i;
  assign ys_r = sc2 ? ((y_r + XW'(1)) >>> 1) : y_r;
  assign ys_i = sc2 ? ((y_i + XW'(1)) >>> 1) : y_i;

  function automatic logic signed [DATA_WIDTH-1:0] clamp(input logic signed [XW-1:0] v);
    if (v > MAXV) return MAXV[DATA_WIDTH-1:0];
    if (v < MINV) return MINV[DATA_WIDTH-1:0];
    return v[DATA_WIDTH-1:0];
  endfunction

  assign o_a_r = clamp(xs_r);
  assign o_a_i = clamp(xs_i);
  assign o_b_r = clamp(ys_r);
  assign o_b_i = clamp(ys_i);

  assign v3_unused_guard = 1'b0;

  // S3 output register: holds steady while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3          <= 1'b0;
      bus.A_out_r <= '0;
      bus.A_out_i <= '0;
      bus.B_out_r <= '0;
      bus.B_out_i <= '0;
    end else if (en) begin
      v3 <= v2 | v3_unused_guard;
      if (v2) begin
        bus.A_out_r <= o_a_r;
        bus.A_out_i <= o_a_i;
        bus.B_out_r <= o_b_r;
        bus.B_out_i <= o_b_i;
      end
    end
  end

`ifdef BFU_PIPE_OVF_FLAG_EN
  function automatic logic hit(input logic signed [XW-1:0] v);
    return (v > MAXV) || (v < MINV);
  endfunction

  logic s3_clamp;
  assign s3_clamp = hit(xs_r) || hit(xs_i) || hit(ys_r) || hit(ys_i);

  // sticky clamp indicator; a new clamp beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_flag <= 1'b0;
    end else if (en && v2 && s3_clamp) begin
      ovf_flag <= 1'b1;
    end else if (ovf_clr) begin
      ovf_flag <= 1'b0;
    end
  end
`endif

endmodule
